// File: rtl/axis_3_to_1_merger_pkg.sv
// Shared definitions for the 3-to-1 AXI4-Stream merger.
//   NUM_INPUTS   : number of merged input streams
//   tkeep_width  : byte-enable width derived from the data width
//   entry_width  : FIFO entry width; entries are packed {tdata, tkeep, tuser, tlast}
//                  so tlast always sits in bit 0 of an entry.
package axis_3_to_1_merger_pkg;

  localparam int unsigned NUM_INPUTS = 3;

  function automatic int unsigned tkeep_width(input int unsigned tdata_width);
    return tdata_width / 8;
  endfunction

  function automatic int unsigned entry_width(input int unsigned tdata_width,
                                              input int unsigned tuser_width);
    return tdata_width + tkeep_width(tdata_width) + tuser_width + 1;
  endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO.
//   clk, reset   : rising-edge clock, synchronous active-high flush
//   din, wr_en   : write port; a write is ignored when the FIFO is full
//   rd_en, dout  : dout shows the head entry whenever empty=0; rd_en pops it
//   nearly_full  : one free slot or fewer remain
//   empty        : no entries held
// A write becomes visible at dout the cycle after it is accepted.
module fallthrough_small_fifo #(
  parameter int unsigned WIDTH          = 72,
  parameter int unsigned MAX_DEPTH_BITS = 3
) (
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty,
  input  logic             reset,
  input  logic             clk
);

  localparam int unsigned DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] FULL_CNT = {1'b1, {MAX_DEPTH_BITS{1'b0}}};
  localparam logic [MAX_DEPTH_BITS:0] NF_CNT   = FULL_CNT - 1'b1;

  logic [WIDTH-1:0]          mem_q [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [MAX_DEPTH_BITS:0]   count_q, count_d;
  logic                      do_wr, do_rd;

  always_comb begin
    do_wr    = wr_en & (count_q != FULL_CNT);
    do_rd    = rd_en & (count_q != '0);
    wr_ptr_d = wr_ptr_q + MAX_DEPTH_BITS'(do_wr);
    rd_ptr_d = rd_ptr_q + MAX_DEPTH_BITS'(do_rd);
    count_d  = count_q + (MAX_DEPTH_BITS+1)'(do_wr) - (MAX_DEPTH_BITS+1)'(do_rd);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only observed through the count.
  always_ff @(posedge clk) begin
    if (do_wr && !reset) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout        = mem_q[rd_ptr_q];
  assign empty       = (count_q == '0);
  assign nearly_full = (count_q >= NF_CNT);

endmodule

// File: rtl/axis_3_to_1_merger.sv
// Merges three AXI4-Stream inputs into one output at packet granularity.
//   axis_aclk / axis_reset        : clock, synchronous active-high reset
//   axis_input_N_*  (N = 0..2)    : slave streams, each buffered by its own FIFO
//   axis_output_*                 : master stream; fields are zero while tvalid=0
// A round-robin arbiter picks a non-empty FIFO in IDLE and stays locked to it
// until the beat carrying tlast is popped; one idle cycle separates packets.
module axis_3_to_1_merger
  import axis_3_to_1_merger_pkg::*;
#(
  parameter  int unsigned TDATA_WIDTH     = 256,
  parameter  int unsigned TUSER_WIDTH     = 128,
  parameter  int unsigned FIFO_DEPTH_BITS = 4,
  localparam int unsigned TKEEP_WIDTH     = tkeep_width(TDATA_WIDTH)
) (
  input  logic                   axis_aclk,
  input  logic                   axis_reset,

  input  logic [TDATA_WIDTH-1:0] axis_input_0_tdata,
  input  logic [TKEEP_WIDTH-1:0] axis_input_0_tkeep,
  input  logic [TUSER_WIDTH-1:0] axis_input_0_tuser,
  input  logic                   axis_input_0_tvalid,
  output logic                   axis_input_0_tready,
  input  logic                   axis_input_0_tlast,

  input  logic [TDATA_WIDTH-1:0] axis_input_1_tdata,
  input  logic [TKEEP_WIDTH-1:0] axis_input_1_tkeep,
  input  logic [TUSER_WIDTH-1:0] axis_input_1_tuser,
  input  logic                   axis_input_1_tvalid,
  output logic                   axis_input_1_tready,
  input  logic                   axis_input_1_tlast,

  input  logic [TDATA_WIDTH-1:0] axis_input_2_tdata,
  input  logic [TKEEP_WIDTH-1:0] axis_input_2_tkeep,
  input  logic [TUSER_WIDTH-1:0] axis_input_2_tuser,
  input  logic                   axis_input_2_tvalid,
  output logic                   axis_input_2_tready,
  input  logic                   axis_input_2_tlast,

  output logic [TDATA_WIDTH-1:0] axis_output_tdata,
  output logic [TKEEP_WIDTH-1:0] axis_output_tkeep,
  output logic [TUSER_WIDTH-1:0] axis_output_tuser,
  output logic                   axis_output_tvalid,
  input  logic                   axis_output_tready,
  output logic                   axis_output_tlast
);

  localparam int unsigned ENTRY_W = entry_width(TDATA_WIDTH, TUSER_WIDTH);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // (base + step) mod 3 for base in 0..2 and step in 1..3.
  function automatic logic [1:0] rr_next(input logic [1:0] base, input logic [1:0] step);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, step};
    if (sum >= 3'd3) begin
      sum = sum - 3'd3;
    end
    return sum[1:0];
  endfunction

  logic [ENTRY_W-1:0]    fifo_din  [NUM_INPUTS];
  logic [ENTRY_W-1:0]    fifo_dout [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] in_valid, in_ready;
  logic [NUM_INPUTS-1:0] fifo_wr, fifo_rd, fifo_empty, fifo_nf;

  logic [0:0]            state_q, state_d;
  logic [1:0]            owner_q, owner_d;
  logic [1:0]            rr_last_q, rr_last_d;

  logic [ENTRY_W-1:0]    head;
  logic                  head_empty;
  logic                  out_valid;
  logic [ENTRY_W-1:0]    out_fields;
  logic [1:0]            cand;
  logic                  found;

  assign fifo_din[0] = {axis_input_0_tdata, axis_input_0_tkeep, axis_input_0_tuser, axis_input_0_tlast};
  assign fifo_din[1] = {axis_input_1_tdata, axis_input_1_tkeep, axis_input_1_tuser, axis_input_1_tlast};
  assign fifo_din[2] = {axis_input_2_tdata, axis_input_2_tkeep, axis_input_2_tuser, axis_input_2_tlast};

  assign in_valid = {axis_input_2_tvalid, axis_input_1_tvalid, axis_input_0_tvalid};
  assign in_ready = ~fifo_nf & {NUM_INPUTS{~axis_reset}};
  assign fifo_wr  = in_valid & in_ready;

  assign axis_input_0_tready = in_ready[0];
  assign axis_input_1_tready = in_ready[1];
  assign axis_input_2_tready = in_ready[2];

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_fifo
    fallthrough_small_fifo #(
      .WIDTH          (ENTRY_W),
      .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
      .din         (fifo_din[g]),
      .wr_en       (fifo_wr[g]),
      .rd_en       (fifo_rd[g]),
      .dout        (fifo_dout[g]),
      .nearly_full (fifo_nf[g]),
      .empty       (fifo_empty[g]),
      .reset       (axis_reset),
      .clk         (axis_aclk)
    );
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_last_d  = rr_last_q;
    fifo_rd    = '0;
    out_valid  = 1'b0;
    cand       = '0;
    found      = 1'b0;

    case (owner_q)
      2'd0:    begin head = fifo_dout[0]; head_empty = fifo_empty[0]; end
      2'd1:    begin head = fifo_dout[1]; head_empty = fifo_empty[1]; end
      default: begin head = fifo_dout[2]; head_empty = fifo_empty[2]; end
    endcase

    case (state_q)
      ST_IDLE: begin
        // Scan rr_last+1, rr_last+2, rr_last+3; the first non-empty FIFO wins.
        for (int unsigned k = 1; k <= 3; k++) begin
          cand = rr_next(rr_last_q, k[1:0]);
          if (!found && |((3'b001 << cand) & ~fifo_empty)) begin
            found     = 1'b1;
            owner_d   = cand;
            rr_last_d = cand;
            state_d   = ST_LOCKED;
          end
        end
      end
      default: begin
        // Stay locked across bubbles; only a popped tlast releases the output.
        out_valid = ~head_empty & ~axis_reset;
        if (out_valid && axis_output_tready) begin
          fifo_rd = 3'b001 << owner_q;
          if (head[0]) begin
            state_d = ST_IDLE;
          end
        end
      end
    endcase

    out_fields = out_valid ? head : '0;
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      rr_last_q <= 2'd2;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
    end
  end

  assign axis_output_tvalid = out_valid;
  assign {axis_output_tdata, axis_output_tkeep, axis_output_tuser, axis_output_tlast} = out_fields;

endmodule

// File: tb/tb_axis_3_to_1_merger.sv
// Directed bench for axis_3_to_1_merger (32-bit data, 8-bit user, 16-deep FIFOs).
module tb_axis_3_to_1_merger;

  logic        clk;
  logic        rst;
  logic [2:0]  in_valid;
  logic [2:0]  in_last;
  logic [31:0] in_data [3];
  logic [3:0]  in_keep [3];
  logic [7:0]  in_user [3];
  logic [2:0]  in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic [7:0]  out_user;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  axis_3_to_1_merger #(
    .TDATA_WIDTH     (32),
    .TUSER_WIDTH     (8),
    .FIFO_DEPTH_BITS (4)
  ) dut (
    .axis_aclk           (clk),
    .axis_reset          (rst),
    .axis_input_0_tdata  (in_data[0]),
    .axis_input_0_tkeep  (in_keep[0]),
    .axis_input_0_tuser  (in_user[0]),
    .axis_input_0_tvalid (in_valid[0]),
    .axis_input_0_tready (in_ready[0]),
    .axis_input_0_tlast  (in_last[0]),
    .axis_input_1_tdata  (in_data[1]),
    .axis_input_1_tkeep  (in_keep[1]),
    .axis_input_1_tuser  (in_user[1]),
    .axis_input_1_tvalid (in_valid[1]),
    .axis_input_1_tready (in_ready[1]),
    .axis_input_1_tlast  (in_last[1]),
    .axis_input_2_tdata  (in_data[2]),
    .axis_input_2_tkeep  (in_keep[2]),
    .axis_input_2_tuser  (in_user[2]),
    .axis_input_2_tvalid (in_valid[2]),
    .axis_input_2_tready (in_ready[2]),
    .axis_input_2_tlast  (in_last[2]),
    .axis_output_tdata   (out_data),
    .axis_output_tkeep   (out_keep),
    .axis_output_tuser   (out_user),
    .axis_output_tvalid  (out_valid),
    .axis_output_tready  (out_ready),
    .axis_output_tlast   (out_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          fire_cnt [3];
  int          first_fire [3];
  logic [2:0]  fire;
  logic [2:0]  idle_shown;
  bit          toggle;
  bit          hold_valid;
  logic [45:0] held;
  logic        vhist [4096];

  // Input beat queues: bit 45 = beat present (0 = one idle cycle), bits 44:0 = payload.
  logic [45:0] q0 [$];
  logic [45:0] q1 [$];
  logic [45:0] q2 [$];
  logic [44:0] obs [$];
  int          obs_t [$];
  logic [44:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [44:0] mk(input int in, input int pkt, input int b, input bit last);
    logic [31:0] d;
    d = {4'hA, 4'(in), 8'(pkt), 16'(b)};
    return {d, (last ? 4'h7 : 4'hF), 4'(in), 4'(b), last};
  endfunction

  task automatic push_raw(input int in, input logic [45:0] e);
    case (in)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic push_pkt(input int in, input int pkt, input int n);
    for (int b = 0; b < n; b++) push_raw(in, {1'b1, mk(in, pkt, b, b == n - 1)});
  endtask

  task automatic exp_pkt(input int in, input int pkt, input int n);
    for (int b = 0; b < n; b++) exp_q.push_back(mk(in, pkt, b, b == n - 1));
  endtask

  task automatic pop_one(input int in);
    case (in)
      0:       if (q0.size() > 0) void'(q0.pop_front());
      1:       if (q1.size() > 0) void'(q1.pop_front());
      default: if (q2.size() > 0) void'(q2.pop_front());
    endcase
  endtask

  task automatic present_one(input int in);
    logic [45:0] h;
    bit          has;
    has = 1'b0;
    h   = '0;
    case (in)
      0:       if (q0.size() > 0) begin has = 1'b1; h = q0[0]; end
      1:       if (q1.size() > 0) begin has = 1'b1; h = q1[0]; end
      default: if (q2.size() > 0) begin has = 1'b1; h = q2[0]; end
    endcase
    in_valid[in] = has && h[45];
    {in_data[in], in_keep[in], in_user[in], in_last[in]} = has ? h[44:0] : '0;
    idle_shown[in] = has && !h[45];
  endtask

  task automatic present_all();
    for (int i = 0; i < 3; i++) present_one(i);
  endtask

  // One clock: observe at the falling edge, advance inputs 1 time unit after the rising edge.
  task automatic step();
    logic [45:0] cur;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      fire[i] = in_valid[i] && in_ready[i];
      if (fire[i]) begin
        fire_cnt[i]++;
        if (first_fire[i] < 0) first_fire[i] = cyc;
      end
    end
    vhist[cyc % 4096] = out_valid;
    cur = {out_valid, out_data, out_keep, out_user, out_last};
    if (hold_valid) check("stall_hold", cur, held);
    hold_valid = out_valid && !out_ready && !rst;
    held = cur;
    if (out_valid && out_ready) begin
      obs.push_back(cur[44:0]);
      obs_t.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (fire[i] || idle_shown[i]) pop_one(i);
      present_one(i);
    end
    if (toggle) out_ready = ~out_ready;
  endtask

  task automatic run_until(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (obs.size() < n && k < budget) begin
      step();
      k++;
    end
    check(tag, obs.size(), n);
  endtask

  task automatic verify(input string tag);
    check({tag, "_count"}, obs.size(), exp_q.size());
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), obs[i], exp_q[i]);
  endtask

  task automatic clear_all();
    q0.delete(); q1.delete(); q2.delete();
    obs.delete(); obs_t.delete(); exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      fire_cnt[i]   = 0;
      first_fire[i] = -1;
    end
    idle_shown = '0;
    fire       = '0;
    hold_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    toggle = 1'b0;
    out_ready = 1'b1;
    clear_all();
    present_all();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int s;
    rst = 1'b1;
    out_ready = 1'b1;
    toggle = 1'b0;
    in_valid = '0;
    in_last = '0;
    for (int i = 0; i < 3; i++) begin
      in_data[i] = '0; in_keep[i] = '0; in_user[i] = '0;
    end
    for (int i = 0; i < 4096; i++) vhist[i] = 1'b0;
    clear_all();

    // Reset state, with an input offering data to prove tready is held low.
    push_pkt(0, 9, 1);
    present_all();
    step();
    step();
    check("rst_tready", in_ready, 3'b000);
    check("rst_tvalid", out_valid, 0);
    check("rst_fields", {out_data, out_keep, out_user, out_last}, 0);
    check("rst_no_accept", fire_cnt[0], 0);

    // 1: single 4-beat packet on input 1.
    do_reset();
    push_pkt(1, 1, 4);
    exp_pkt(1, 1, 4);
    present_all();
    run_until("t1_drain", 4, 40);
    step();
    s = first_fire[1];
    if (obs_t.size() >= 4) begin
      check("t1_first_latency", obs_t[0], s + 2);
      check("t1_last_cycle", obs_t[3], s + 5);
    end
    check("t1_bubble", vhist[(s + 6) % 4096], 0);
    verify("t1");

    // 2: 2-beat packets on all inputs at once, two rounds each.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push_pkt(i, 0, 2);
      push_pkt(i, 1, 2);
    end
    exp_pkt(0, 0, 2); exp_pkt(1, 0, 2); exp_pkt(2, 0, 2);
    exp_pkt(0, 1, 2); exp_pkt(1, 1, 2); exp_pkt(2, 1, 2);
    present_all();
    run_until("t2_drain", 12, 80);
    if (obs_t.size() >= 3) check("t2_gap", obs_t[2] - obs_t[1], 2);
    verify("t2");

    // 3: output tready toggling during an 8-beat packet on input 2.
    do_reset();
    push_pkt(2, 3, 8);
    exp_pkt(2, 3, 8);
    toggle = 1'b1;
    present_all();
    run_until("t3_drain", 8, 80);
    toggle = 1'b0;
    out_ready = 1'b1;
    verify("t3");

    // 4: fill FIFO 0 with the output stalled, then drain.
    do_reset();
    out_ready = 1'b0;
    push_pkt(0, 4, 20);
    exp_pkt(0, 4, 20);
    present_all();
    for (int k = 0; k < 25; k++) step();
    check("t4_accepted", fire_cnt[0], 15);
    check("t4_tready", in_ready, 3'b110);
    check("t4_stalled_out", obs.size(), 0);
    out_ready = 1'b1;
    run_until("t4_drain", 20, 80);
    verify("t4");

    // 5: one-cycle reset while beat 3 of a 6-beat packet is offered.
    do_reset();
    push_pkt(1, 5, 6);
    present_all();
    for (int k = 0; k < 20 && fire_cnt[1] < 2; k++) step();
    check("t5_pre_accepted", fire_cnt[1], 2);
    rst = 1'b1;
    #1;
    check("t5_rst_tready", in_ready, 3'b000);
    check("t5_rst_tvalid", out_valid, 0);
    step();
    rst = 1'b0;
    clear_all();
    present_all();
    #1;
    check("t5_after_tvalid", out_valid, 0);
    step();
    check("t5_empty_tvalid", out_valid, 0);
    push_pkt(2, 6, 2);
    push_pkt(0, 6, 2);
    exp_pkt(0, 6, 2);
    exp_pkt(2, 6, 2);
    present_all();
    run_until("t5_drain", 4, 40);
    for (int k = 0; k < 4; k++) step();
    verify("t5");

    // 6: bubble inside input 1's packet while input 0 waits.
    do_reset();
    push_raw(1, {1'b1, mk(1, 7, 0, 1'b0)});
    for (int k = 0; k < 5; k++) push_raw(1, '0);
    push_raw(1, {1'b1, mk(1, 7, 1, 1'b0)});
    push_raw(1, {1'b1, mk(1, 7, 2, 1'b1)});
    exp_q.push_back(mk(1, 7, 0, 1'b0));
    exp_q.push_back(mk(1, 7, 1, 1'b0));
    exp_q.push_back(mk(1, 7, 2, 1'b1));
    exp_pkt(0, 8, 2);
    present_all();
    step();
    push_pkt(0, 8, 2);
    present_one(0);
    run_until("t6_drain", 5, 60);
    verify("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
